// File: rtl/doitgen.sv
// doitgen row transformer: Aout[p] = sum_{s<np} A[s]*C4[s][p] over an nr x nq frame, one row per beat.
// Define DOITGEN_SATURATE_EN to clamp each result lane at 255 instead of wrapping modulo 256.
module doitgen #(
  parameter int NP_MAX = 4,
  parameter int LW     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] nr,
  input  logic [31:0] nq,
  input  logic [31:0] np,
  input  logic        x_load,
  input  logic [1:0]  x_row,
  input  logic [0:31] X,
  input  logic        a_valid,
  input  logic [0:31] A,
  output logic        a_ready,
  output logic [0:31] Aout,
  output logic        aout_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg;
  logic [LW-1:0]  coef_reg [NP_MAX][NP_MAX];
  logic [31:0]    nr_reg, nq_reg, q_reg, r_reg;
  logic [2:0]     np_reg;
  logic [0:31]    aout_reg;
  logic           aout_valid_reg, busy_reg, done_reg;

  logic [LW-1:0]  a_lane   [NP_MAX];
  logic [LW-1:0]  res_lane [NP_MAX];
  logic           lane_en  [NP_MAX];

  // lane 0 sits in the most significant byte of the ascending-range bus
  for (genvar gi = 0; gi < NP_MAX; gi++) begin : g_lane
    logic [17:0] sum;
    logic [15:0] prod;

    assign a_lane[gi]  = A[gi*LW +: LW];
    assign lane_en[gi] = (np_reg > 3'(gi));

    always_comb begin
      sum  = '0;
      prod = '0;
      for (int s = 0; s < NP_MAX; s++) begin
        prod = 16'(a_lane[s]) * 16'(coef_reg[s][gi]);
        if (lane_en[s]) sum = sum + 18'(prod);
      end
    end

`ifdef DOITGEN_SATURATE_EN
    assign res_lane[gi] = !lane_en[gi] ? '0 : ((sum > 18'd255) ? 8'hFF : sum[7:0]);
`else
    assign res_lane[gi] = lane_en[gi] ? sum[7:0] : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      aout_valid_reg <= 1'b0;
      aout_reg       <= '0;
      nr_reg         <= '0;
      nq_reg         <= '0;
      np_reg         <= '0;
      q_reg          <= '0;
      r_reg          <= '0;
      for (int s = 0; s < NP_MAX; s++)
        for (int k = 0; k < NP_MAX; k++)
          coef_reg[s][k] <= '0;
    end else begin
      done_reg       <= 1'b0;
      aout_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (x_load)
            for (int k = 0; k < NP_MAX; k++)
              coef_reg[x_row][k] <= X[k*LW +: LW];
          if (start) begin
            nr_reg <= nr;
            nq_reg <= nq;
            np_reg <= (np > 32'd4) ? 3'd4 : np[2:0];
            q_reg  <= '0;
            r_reg  <= '0;
            if (nr == 32'd0 || nq == 32'd0 || np == 32'd0) begin
              done_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (a_valid) begin
            for (int k = 0; k < NP_MAX; k++)
              aout_reg[k*LW +: LW] <= res_lane[k];
            aout_valid_reg <= 1'b1;
            if (q_reg == nq_reg - 32'd1) begin
              q_reg <= '0;
              if (r_reg == nr_reg - 32'd1) begin
                r_reg     <= '0;
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                r_reg <= r_reg + 32'd1;
              end
            end else begin
              q_reg <= q_reg + 32'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign a_ready    = busy_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign aout_valid = aout_valid_reg;
  assign Aout       = aout_reg;

endmodule

// File: tb/tb_doitgen.sv
// Directed self-checking bench for doitgen; each scenario task checks its own results.
module tb_doitgen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] nr, nq, np;
  logic        x_load;
  logic [1:0]  x_row;
  logic [0:31] X;
  logic        a_valid;
  logic [0:31] A;
  logic        a_ready;
  logic [0:31] Aout;
  logic        aout_valid;
  logic        busy;
  logic        done;

  int test_count = 0;
  int fail_count = 0;

  doitgen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nr(nr), .nq(nq), .np(np),
    .x_load(x_load), .x_row(x_row), .X(X), .a_valid(a_valid), .A(A),
    .a_ready(a_ready), .Aout(Aout), .aout_valid(aout_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [1:0] row, input logic [31:0] data);
    x_load = 1'b1; x_row = row; X = data;
    tick();
    x_load = 1'b0;
  endtask

  task automatic load_all(input logic [31:0] r0, r1, r2, r3);
    load_row(2'd0, r0); load_row(2'd1, r1); load_row(2'd2, r2); load_row(2'd3, r3);
  endtask

  task automatic start_frame(input logic [31:0] vr, vq, vp);
    nr = vr; nq = vq; np = vp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // single-row frame: send one beat and check result, done and busy together
  task automatic single_beat(input string name, input logic [31:0] vp,
                             input logic [31:0] a, input logic [31:0] exp);
    start_frame(32'd1, 32'd1, vp);
    A = a; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    test_count++;
    if (Aout !== exp || aout_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      fail_count++;
      $display("FAIL %s: Aout=%h valid=%b done=%b busy=%b, expected Aout=%h valid=1 done=1 busy=0",
               name, Aout, aout_valid, done, busy, exp);
    end else $display("[TB] %s: Aout=%h ok", name, Aout);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x_load = 1'b0; a_valid = 1'b0;
    nr = '0; nq = '0; np = '0; x_row = '0; X = 32'hFFFFFFFF; A = 32'hFFFFFFFF;
    tick(); tick();
    rst_n = 1'b1;
    test_count++;
    if (Aout !== 32'h0 || aout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || a_ready !== 1'b0) begin
      fail_count++;
      $display("FAIL reset: Aout=%h valid=%b busy=%b done=%b ready=%b, expected all 0",
               Aout, aout_valid, busy, done, a_ready);
    end else $display("[TB] reset: outputs zero");
    A = '0; X = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      test_count++;
      if (Aout !== 32'h0 || aout_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        fail_count++;
        $display("FAIL idle_quiet: cycle %0d Aout=%h valid=%b busy=%b done=%b, expected all 0",
                 i, Aout, aout_valid, busy, done);
      end
    end
    $display("[TB] idle: 100 ns quiet checked");
  endtask

  task automatic test_identity();
    load_all(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    start_frame(32'd1, 32'd1, 32'd4);
    test_count++;
    if (busy !== 1'b1 || a_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL identity_busy: busy=%b ready=%b, expected 1 1", busy, a_ready);
    end
    A = 32'h01020304; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    test_count++;
    if (Aout !== 32'h01020304 || aout_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      fail_count++;
      $display("FAIL identity: Aout=%h valid=%b done=%b busy=%b, expected 01020304 1 1 0",
               Aout, aout_valid, done, busy);
    end else $display("[TB] identity: Aout=%h ok", Aout);
    A = 32'hDEADBEEF;
    tick();
    test_count++;
    if (Aout !== 32'h01020304 || aout_valid !== 1'b0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL identity_hold: Aout=%h valid=%b done=%b, expected 01020304 0 0",
               Aout, aout_valid, done);
    end else $display("[TB] identity_hold: Aout held");
  endtask

  task automatic test_all_ones();
    load_all(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    single_beat("ones_np4", 32'd4, 32'h01020304, 32'h0A0A0A0A);
    single_beat("ones_np2", 32'd2, 32'h01020304, 32'h03030000);
    single_beat("ones_np1", 32'd1, 32'h01020304, 32'h01000000);
  endtask

  task automatic test_wrap();
    load_all(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
`ifdef DOITGEN_SATURATE_EN
    single_beat("wrap", 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    single_beat("wrap", 32'd4, 32'hFFFFFFFF, 32'h04040404);
`endif
  endtask

  task automatic test_back_to_back();
    int valid_cnt = 0, done_cnt = 0, bad_data = 0, done_iter = -1, last_valid = -1;
    logic [31:0] v;
    load_all(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    start_frame(32'd10, 32'd10, 32'd10);
    a_valid = 1'b1;
    for (int i = 0; i < 110; i++) begin
      v = {8'(i), 8'(i + 7), 8'(i * 3), 8'(255 - i)};
      A = v;
      tick();
      if (aout_valid === 1'b1) begin
        valid_cnt++; last_valid = i;
        if (Aout !== v) bad_data++;
      end
      if (done === 1'b1) begin done_cnt++; done_iter = i; end
    end
    a_valid = 1'b0;
    test_count++;
    if (valid_cnt != 100 || done_cnt != 1 || done_iter != 99 || last_valid != 99 || bad_data != 0) begin
      fail_count++;
      $display("FAIL frame_10x10: valids=%0d dones=%0d done_at=%0d last_valid=%0d bad=%0d, expected 100 1 99 99 0",
               valid_cnt, done_cnt, done_iter, last_valid, bad_data);
    end else $display("[TB] frame_10x10: 100 rows, single done");
    test_count++;
    if (busy !== 1'b0) begin
      fail_count++;
      $display("FAIL frame_idle: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_xload_run();
    load_all(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    start_frame(32'd1, 32'd2, 32'd4);
    x_load = 1'b1; x_row = 2'd0; X = 32'h00000000; start = 1'b1;
    tick();
    x_load = 1'b0; start = 1'b0;
    A = 32'h01020304; a_valid = 1'b1;
    tick();
    test_count++;
    if (Aout !== 32'h0A0A0A0A || aout_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      fail_count++;
      $display("FAIL xload_run_b0: Aout=%h valid=%b done=%b busy=%b, expected 0A0A0A0A 1 0 1",
               Aout, aout_valid, done, busy);
    end else $display("[TB] xload_run_b0: Aout=%h ok", Aout);
    A = 32'h04030201;
    tick();
    a_valid = 1'b0;
    test_count++;
    if (Aout !== 32'h0A0A0A0A || aout_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      fail_count++;
      $display("FAIL xload_run_b1: Aout=%h valid=%b done=%b busy=%b, expected 0A0A0A0A 1 1 0",
               Aout, aout_valid, done, busy);
    end else $display("[TB] xload_run_b1: C4 unchanged");
  endtask

  task automatic test_start_with_load();
    load_all(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    x_load = 1'b1; x_row = 2'd0; X = 32'h02000000;
    start_frame(32'd1, 32'd1, 32'd4);
    x_load = 1'b0;
    A = 32'h01020304; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    test_count++;
    if (Aout !== 32'h02020304 || aout_valid !== 1'b1) begin
      fail_count++;
      $display("FAIL start_with_load: Aout=%h valid=%b, expected 02020304 1", Aout, aout_valid);
    end else $display("[TB] start_with_load: Aout=%h ok", Aout);
  endtask

  task automatic test_zero_frame();
    logic [31:0] dims [3][3];
    dims[0] = '{32'd0, 32'd3, 32'd4};
    dims[1] = '{32'd3, 32'd0, 32'd4};
    dims[2] = '{32'd3, 32'd3, 32'd0};
    for (int k = 0; k < 3; k++) begin
      start_frame(dims[k][0], dims[k][1], dims[k][2]);
      test_count++;
      if (done !== 1'b1 || busy !== 1'b0) begin
        fail_count++;
        $display("FAIL zero_frame%0d: done=%b busy=%b, expected 1 0", k, done, busy);
      end
      tick();
      test_count++;
      if (done !== 1'b0 || busy !== 1'b0 || aout_valid !== 1'b0) begin
        fail_count++;
        $display("FAIL zero_frame%0d_after: done=%b busy=%b valid=%b, expected 0 0 0",
                 k, done, busy, aout_valid);
      end else $display("[TB] zero_frame%0d: single done, stays idle", k);
    end
  endtask

  task automatic test_reset_midframe();
    load_all(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    start_frame(32'd2, 32'd2, 32'd4);
    A = 32'h01020304; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    test_count++;
    if (busy !== 1'b0 || done !== 1'b0 || aout_valid !== 1'b0 || Aout !== 32'h0) begin
      fail_count++;
      $display("FAIL reset_mid: busy=%b done=%b valid=%b Aout=%h, expected 0 0 0 0",
               busy, done, aout_valid, Aout);
    end else $display("[TB] reset_mid: frame aborted");
    single_beat("c4_cleared", 32'd4, 32'h01020304, 32'h00000000);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_all_ones();
    test_wrap();
    test_back_to_back();
    test_xload_run();
    test_start_with_load();
    test_zero_frame();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end
endmodule
